// File: rtl/unidade_controle_jogada.sv
// rtl/unidade_controle_jogada.sv - Moore control FSM for turn capture, player toggling and inactivity timeout
//
// Purpose: sequences each turn as macro-board selection followed by micro-cell
// selection, driving the clear/load strobes of the play-capture datapath.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous active-low reset
//   iniciar          start/restart request (honoured in inicial, fim, estouro)
//   tem_jogada       one-cycle button pulse from the datapath edge detector
//   macro_valida     registered macro board is playable
//   micro_valida     registered micro cell is free
//   fim_jogo         win or draw detected after the last micro write
//   zeraEdge         clears the edge detector
//   zeraR_macro      clears the macro register
//   zeraR_micro      clears the micro register
//   registraR_macro  loads the macro register
//   registraR_micro  loads the micro register
//   jogador          current player (0 = X, 1 = O)
//   pronto           game finished normally
//   timeout          game aborted by inactivity
//   db_estado        current state code
module unidade_controle_jogada #(
    parameter int TIMEOUT = 5000,
    parameter int CNT_W   = 13
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       tem_jogada,
    input  logic       macro_valida,
    input  logic       micro_valida,
    input  logic       fim_jogo,
    output logic       zeraEdge,
    output logic       zeraR_macro,
    output logic       zeraR_micro,
    output logic       registraR_macro,
    output logic       registraR_micro,
    output logic       jogador,
    output logic       pronto,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        ESPERA_MACRO   = 4'h2,
        REGISTRA_MACRO = 4'h3,
        VALIDA_MACRO   = 4'h4,
        ESPERA_MICRO   = 4'h5,
        REGISTRA_MICRO = 4'h6,
        VALIDA_MICRO   = 4'h7,
        VERIFICA_FIM   = 4'h8,
        TROCA_JOGADOR  = 4'h9,
        FIM            = 4'hA,
        ESTOURO        = 4'hB
    } state_t;

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_jogador;
    logic             w_espera;
    logic             w_expirou;

    assign w_espera  = (r_state == ESPERA_MACRO) || (r_state == ESPERA_MICRO);
    // A pulse on the last allowed cycle takes priority over the timeout.
    assign w_expirou = w_espera && !tem_jogada && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= INICIAL;
        end else begin
            r_state <= w_next;
        end
    end

    // Counter runs only while staying in a wait state; any exit, entry or
    // pulse leaves it at zero, so entry from a validation state starts fresh.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_espera && !tem_jogada && !w_expirou) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_jogador <= 1'b0;
        end else if (r_state == PREPARACAO) begin
            r_jogador <= 1'b0;
        end else if (r_state == TROCA_JOGADOR) begin
            r_jogador <= ~r_jogador;
        end
    end

    always_comb begin
        w_next = INICIAL;
        case (r_state)
            INICIAL:        w_next = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     w_next = ESPERA_MACRO;
            ESPERA_MACRO:   w_next = tem_jogada ? REGISTRA_MACRO :
                                     (w_expirou ? ESTOURO : ESPERA_MACRO);
            REGISTRA_MACRO: w_next = VALIDA_MACRO;
            VALIDA_MACRO:   w_next = macro_valida ? ESPERA_MICRO : ESPERA_MACRO;
            ESPERA_MICRO:   w_next = tem_jogada ? REGISTRA_MICRO :
                                     (w_expirou ? ESTOURO : ESPERA_MICRO);
            REGISTRA_MICRO: w_next = VALIDA_MICRO;
            VALIDA_MICRO:   w_next = micro_valida ? VERIFICA_FIM : ESPERA_MICRO;
            VERIFICA_FIM:   w_next = fim_jogo ? FIM : TROCA_JOGADOR;
            TROCA_JOGADOR:  w_next = ESPERA_MACRO;
            FIM:            w_next = iniciar ? PREPARACAO : FIM;
            ESTOURO:        w_next = iniciar ? PREPARACAO : ESTOURO;
            default:        w_next = INICIAL;
        endcase
    end

    always_comb begin
        zeraEdge        = 1'b0;
        zeraR_macro     = 1'b0;
        zeraR_micro     = 1'b0;
        registraR_macro = 1'b0;
        registraR_micro = 1'b0;
        pronto          = 1'b0;
        timeout         = 1'b0;
        case (r_state)
            PREPARACAO: begin
                zeraEdge    = 1'b1;
                zeraR_macro = 1'b1;
                zeraR_micro = 1'b1;
            end
            REGISTRA_MACRO: registraR_macro = 1'b1;
            REGISTRA_MICRO: registraR_micro = 1'b1;
            TROCA_JOGADOR:  zeraR_micro     = 1'b1;
            FIM:            pronto          = 1'b1;
            ESTOURO:        timeout         = 1'b1;
            default: ;
        endcase
    end

    assign jogador   = r_jogador;
    assign db_estado = r_state;

endmodule
